// File: rtl/draw_layer_arbiter.sv
// Composites up to four sprite layers over the map background, with a frame-synchronous
// layer-enable mask and per-frame obstacle-collision flags.
module draw_layer_arbiter #(
   parameter int          MAP_LATENCY = 2,
   parameter logic [11:0] BG_RGB      = 12'hEC1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_map_in,
   input  logic [3:0]  layer_valid,
   input  logic [47:0] layer_rgb,
   input  logic        cfg_req,
   input  logic [3:0]  cfg_en_in,
   output logic        cfg_ack,
   output logic        cfg_busy,
   output logic [3:0]  layer_en,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out,
   output logic [3:0]  col_frame,
   output logic        col_strobe
);

   localparam int TW    = 25;
   localparam int DEPTH = MAP_LATENCY + 1;

   typedef enum logic {IDLE, PENDING} cfg_state_t;

   logic [TW-1:0] tim_in;
   logic [TW-1:0] tim_q [DEPTH];
   logic [TW-1:0] tim_al;

   cfg_state_t  state_q;
   logic [3:0]  shadow_q;
   logic [3:0]  layer_en_q;
   logic        cfg_ack_q;
   logic [3:0]  acc_q;
   logic [3:0]  col_frame_q;
   logic        col_strobe_q;
   logic        vblnk_prev_q;
   logic [11:0] rgb_q;
   logic [11:0] rgb_d;

   logic       al_hblnk;
   logic       al_vblnk;
   logic       active;
   logic       vblank_rise;
   logic [3:0] hit;

   assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

   // Tap MAP_LATENCY-1 carries the timing that matches the map/layer pixel arriving now.
   generate
      if (MAP_LATENCY == 0) begin : g_no_lat
         assign tim_al = tim_in;
      end else begin : g_lat
         assign tim_al = tim_q[MAP_LATENCY-1];
      end
   endgenerate

   // NOTE: every clocked register below uses non-blocking assignment so all stages shift together.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) tim_q[i] <= '0;
      end else begin
         tim_q[0] <= tim_in;
         for (int i = 1; i < DEPTH; i++) tim_q[i] <= tim_q[i-1];
      end
   end

   assign al_hblnk    = tim_al[1];
   assign al_vblnk    = tim_al[0];
   assign active      = ~al_hblnk & ~al_vblnk;
   assign vblank_rise = al_vblnk & ~vblnk_prev_q;
   assign hit         = layer_valid & layer_en_q & {4{rgb_map_in != BG_RGB}};

   // NOTE: rgb_d gets a default before the loop, so no latch; later (higher) layers win.
   always_comb begin
      rgb_d = rgb_map_in;
      for (int k = 0; k < 4; k++) begin
         if (layer_valid[k] && layer_en_q[k]) rgb_d = layer_rgb[12*k +: 12];
      end
      if (!active) rgb_d = 12'h000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shadow_q     <= 4'hF;
         layer_en_q   <= 4'hF;
         cfg_ack_q    <= 1'b0;
         acc_q        <= 4'h0;
         col_frame_q  <= 4'h0;
         col_strobe_q <= 1'b0;
         vblnk_prev_q <= 1'b0;
         rgb_q        <= 12'h000;
      end else begin
         vblnk_prev_q <= al_vblnk;
         rgb_q        <= rgb_d;
         cfg_ack_q    <= 1'b0;
         col_strobe_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (cfg_req) begin
                  shadow_q <= cfg_en_in;
                  state_q  <= PENDING;
               end
            end
            PENDING: begin
               // A request landing on the edge itself is the freshest one and wins.
               if (vblank_rise) begin
                  layer_en_q <= cfg_req ? cfg_en_in : shadow_q;
                  if (cfg_req) shadow_q <= cfg_en_in;
                  cfg_ack_q  <= 1'b1;
                  state_q    <= IDLE;
               end else if (cfg_req) begin
                  shadow_q <= cfg_en_in;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (vblank_rise) begin
            col_frame_q  <= acc_q;
            acc_q        <= 4'h0;
            col_strobe_q <= 1'b1;
         end else if (active) begin
            acc_q <= acc_q | hit;
         end
      end
   end

   assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_q[DEPTH-1];

   assign rgb_out    = rgb_q;
   assign layer_en   = layer_en_q;
   assign cfg_ack    = cfg_ack_q;
   assign cfg_busy   = (state_q == PENDING);
   assign col_frame  = col_frame_q;
   assign col_strobe = col_strobe_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed bench for draw_layer_arbiter: a cycle model built from the compositing rules is
// compared every cycle, and literal expectations pin the key scenarios.
module tb_draw_layer_arbiter;

   localparam logic [11:0] BG   = 12'hEC1;
   localparam logic [47:0] LRGB = {12'h0F0, 12'hF00, 12'h0A0, 12'h00F};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_map_in = '0;
   logic [3:0]  layer_valid = '0;
   logic [47:0] layer_rgb = '0;
   logic        cfg_req = 1'b0;
   logic [3:0]  cfg_en_in = '0;
   logic        cfg_ack, cfg_busy;
   logic [3:0]  layer_en;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   logic [3:0]  col_frame;
   logic        col_strobe;

   int total = 0;
   int bad   = 0;
   int acks_seen = 0;
   int strobes_seen = 0;

   draw_layer_arbiter #(.MAP_LATENCY(2), .BG_RGB(BG)) dut (
      .clk(clk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_map_in(rgb_map_in), .layer_valid(layer_valid), .layer_rgb(layer_rgb),
      .cfg_req(cfg_req), .cfg_en_in(cfg_en_in), .cfg_ack(cfg_ack), .cfg_busy(cfg_busy),
      .layer_en(layer_en),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .col_frame(col_frame), .col_strobe(col_strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [24:0] tq[$];
   logic [3:0]  m_en, m_shadow, m_acc;
   logic        m_pend, m_prev_vb;
   logic [24:0] e_tim;
   logic [11:0] e_rgb;
   logic [3:0]  e_en, e_frame;
   logic        e_ack, e_busy, e_strobe;
   bit          model_ok = 0;

   always @(posedge clk) begin
      logic [24:0] al;
      logic        rise;
      int          top;
      if (rst) begin
         tq.delete();
         tq = '{25'd0, 25'd0, 25'd0};
         m_en = 4'hF; m_shadow = 4'hF; m_acc = 4'h0; m_pend = 0; m_prev_vb = 0;
         e_tim = '0; e_rgb = '0; e_en = 4'hF; e_frame = 4'h0; e_ack = 0; e_busy = 0; e_strobe = 0;
      end else begin
         tq.push_back({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in});
         void'(tq.pop_front());
         al   = tq[0];
         rise = al[0] && !m_prev_vb;
         m_prev_vb = al[0];
         e_tim = al;

         top = -1;
         for (int k = 3; k >= 0; k--) begin
            if (layer_valid[k] && m_en[k]) begin
               top = k;
               break;
            end
         end
         if (al[1] || al[0]) e_rgb = 12'h000;
         else if (top < 0)   e_rgb = rgb_map_in;
         else                e_rgb = layer_rgb[12*top +: 12];

         e_strobe = rise;
         if (rise) begin
            e_frame = m_acc;
            m_acc   = 4'h0;
         end else if (!al[1] && !al[0] && rgb_map_in != BG) begin
            m_acc = m_acc | (layer_valid & m_en);
         end

         e_ack = 0;
         if (m_pend && rise) begin
            m_en   = cfg_req ? cfg_en_in : m_shadow;
            m_pend = 0;
            e_ack  = 1;
         end else if (cfg_req) begin
            m_shadow = cfg_en_in;
            m_pend   = 1;
         end
         e_en   = m_en;
         e_busy = m_pend;
      end
      model_ok = 1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("hcount_out", 32'(hcount_out), 32'(e_tim[24:14]));
         check("vcount_out", 32'(vcount_out), 32'(e_tim[13:4]));
         check("hsync_out",  32'(hsync_out),  32'(e_tim[3]));
         check("vsync_out",  32'(vsync_out),  32'(e_tim[2]));
         check("hblnk_out",  32'(hblnk_out),  32'(e_tim[1]));
         check("vblnk_out",  32'(vblnk_out),  32'(e_tim[0]));
         check("rgb_out",    32'(rgb_out),    32'(e_rgb));
         check("layer_en",   32'(layer_en),   32'(e_en));
         check("cfg_ack",    32'(cfg_ack),    32'(e_ack));
         check("cfg_busy",   32'(cfg_busy),   32'(e_busy));
         check("col_frame",  32'(col_frame),  32'(e_frame));
         check("col_strobe", 32'(col_strobe), 32'(e_strobe));
         if (cfg_ack)    acks_seen++;
         if (col_strobe) strobes_seen++;
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic        hb, vb;
      logic [11:0] map;
      logic [3:0]  valid;
      logic [47:0] lrgb;
   } pix_t;

   pix_t        pq[$];
   logic [10:0] hc = '0;
   logic [9:0]  vc = '0;

   // Timing goes out now; the map/layer data of the pixel timed two steps ago goes out with it.
   task automatic drive(input pix_t p, input logic req, input logic [3:0] en);
      pix_t d;
      @(posedge clk);
      #1;
      hcount_in = p.h; vcount_in = p.v; hblnk_in = p.hb; vblnk_in = p.vb;
      hsync_in  = p.hb & p.h[0];
      vsync_in  = p.vb & p.v[0];
      pq.push_back(p);
      d = pq.pop_front();
      rgb_map_in = d.map; layer_valid = d.valid; layer_rgb = d.lrgb;
      cfg_req = req; cfg_en_in = en;
   endtask

   task automatic pixels(input int n, input logic hb, input logic vb, input logic [11:0] map,
                         input logic [3:0] valid, input int req_at, input logic [3:0] en);
      pix_t p;
      for (int i = 0; i < n; i++) begin
         p.h = hc; p.v = vc; p.hb = hb; p.vb = vb; p.map = map; p.valid = valid; p.lrgb = LRGB;
         drive(p, i == req_at, en);
         hc = 11'(hc + 1);
      end
   endtask

   task automatic act(input int n, input logic [11:0] map, input logic [3:0] valid,
                      input int req_at, input logic [3:0] en);
      pixels(n, 1'b0, 1'b0, map, valid, req_at, en);
   endtask

   task automatic vblank(input int n, input int req_at, input logic [3:0] en);
      pixels(n, 1'b0, 1'b1, BG, 4'h0, req_at, en);
      hc = '0;
      vc = '0;
   endtask

   int acks0, strobes0;

   initial begin
      pix_t z;
      z.h = '0; z.v = '0; z.hb = 0; z.vb = 0; z.map = BG; z.valid = '0; z.lrgb = LRGB;
      pq.push_back(z);
      pq.push_back(z);

      // Reset state
      rst = 1'b1;
      pixels(2, 1'b1, 1'b0, BG, 4'h0, -1, 4'h0);
      check("rst layer_en", 32'(layer_en), 32'hF);
      check("rst rgb_out", 32'(rgb_out), 32'h0);
      check("rst cfg_busy", 32'(cfg_busy), 32'h0);
      check("rst col_frame", 32'(col_frame), 32'h0);
      rst = 1'b0;

      // Latency and priority (frame A), then request mask 4'b1011
      hc = 11'd100;
      act(4, BG, 4'b0101, -1, 4'h0);
      check("latency hcount", 32'(hcount_out), 32'd100);
      act(4, BG, 4'b0101, -1, 4'h0);
      check("prio full mask", 32'(rgb_out), 32'hF00);
      act(2, BG, 4'b0101, 0, 4'b1011);
      check("busy after req", 32'(cfg_busy), 32'h1);
      check("en held mid-frame", 32'(layer_en), 32'hF);
      vblank(6, -1, 4'h0);
      check("en after vblank A", 32'(layer_en), 32'hB);

      // Frame B: new priority, blanked pixel, two requests before the edge
      act(5, BG, 4'b0101, -1, 4'h0);
      check("prio mask B", 32'(rgb_out), 32'h00F);
      pixels(1, 1'b1, 1'b0, 12'h777, 4'hF, -1, 4'h0);
      act(3, BG, 4'h0, 0, 4'h3);
      check("blank rgb", 32'(rgb_out), 32'h0);
      act(3, BG, 4'h0, 1, 4'h6);
      check("busy before edge", 32'(cfg_busy), 32'h1);
      acks0 = acks_seen;
      vblank(6, -1, 4'h0);
      check("last req wins", 32'(layer_en), 32'h6);
      check("single ack", 32'(acks_seen - acks0), 32'd1);
      check("busy after edge", 32'(cfg_busy), 32'h0);
      check("no blank collision", 32'(col_frame), 32'h0);

      // Frame C: one layer-1 pixel over an obstacle
      strobes0 = strobes_seen;
      act(3, BG, 4'h0, -1, 4'h0);
      act(1, 12'h777, 4'b0010, -1, 4'h0);
      act(3, BG, 4'h0, -1, 4'h0);
      vblank(6, -1, 4'h0);
      check("collision layer1", 32'(col_frame), 32'b0010);
      check("one strobe", 32'(strobes_seen - strobes0), 32'd1);

      // Frame D: only a disabled layer over obstacles
      act(4, 12'h777, 4'b1000, -1, 4'h0);
      vblank(6, -1, 4'h0);
      check("clean frame", 32'(col_frame), 32'h0);

      // Frame E: request coincident with the edge while pending
      act(3, BG, 4'h0, 1, 4'h5);
      vblank(6, 2, 4'h9);
      check("coincident pending", 32'(layer_en), 32'h9);
      check("busy E", 32'(cfg_busy), 32'h0);

      // Frame F/G: request coincident with the edge while idle
      act(3, BG, 4'h0, -1, 4'h0);
      vblank(6, 2, 4'hC);
      check("coincident idle held", 32'(layer_en), 32'h9);
      check("coincident idle busy", 32'(cfg_busy), 32'h1);
      act(3, BG, 4'h0, -1, 4'h0);
      vblank(6, -1, 4'h0);
      check("applied next frame", 32'(layer_en), 32'hC);

      // Frame H: reset while pending, collisions before reset discarded
      act(3, BG, 4'h0, 0, 4'h1);
      act(2, 12'h777, 4'b0100, -1, 4'h0);
      act(3, BG, 4'h0, -1, 4'h0);
      rst = 1'b1;
      act(1, BG, 4'h0, -1, 4'h0);
      rst = 1'b0;
      act(1, BG, 4'h0, -1, 4'h0);
      check("rst en", 32'(layer_en), 32'hF);
      check("rst busy", 32'(cfg_busy), 32'h0);
      acks0 = acks_seen;
      act(2, 12'h777, 4'b1000, -1, 4'h0);
      act(3, BG, 4'h0, -1, 4'h0);
      vblank(6, -1, 4'h0);
      check("no ack after rst", 32'(acks_seen - acks0), 32'd0);
      check("collision since rst", 32'(col_frame), 32'b1000);

      act(3, BG, 4'h0, -1, 4'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
